// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Segment codes are active-high with bit 0 = a ... bit 6 = g.
package bcd_display_scanner_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    // Map an active-high segment pattern onto the board pin polarity.
    function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder with a blank override.
// Non-decimal codes show a dash so corrupted counter values are visible.
module bcd_to_seg7
    import bcd_display_scanner_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    input  logic               blank,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: per-frame snapshot of packed BCD digits,
// one digit per slot with a blank gap at slot start, leading-zero blanking.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int N_DIGITS       = 6,
    parameter int PRESCALE       = 50000,
    parameter int GAP            = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                        CLK_IN,
    input  logic                        RST,
    input  logic [DIGIT_W*N_DIGITS-1:0] BCD_IN,
    input  logic [N_DIGITS-1:0]         DP_IN,
    input  logic                        BLANK_LZ,
    output logic [6:0]                  SEG,
    output logic                        DP,
    output logic [N_DIGITS-1:0]         DIG,
    output logic                        FRAME_TICK
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]    PRE_GAP  = PRE_W'(GAP);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_IDLE = seg_pol(SEG_OFF, SEG_ACTIVE_LOW);
    localparam logic [N_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

    logic [PRE_W-1:0]              pre, pre_n;
    logic [IDX_W-1:0]              idx, idx_n;
    logic [DIGIT_W*N_DIGITS-1:0]   snap_bcd, snap_bcd_n;
    logic [N_DIGITS-1:0]           snap_dp, snap_dp_n;
    logic                          snap_lz, snap_lz_n;

    logic [6:0]                    seg_q, seg_n;
    logic                          dp_q, dp_n;
    logic [N_DIGITS-1:0]           dig_q, dig_n;
    logic                          tick_q, tick_n;

    phase_t                        phase_n;
    logic [DIGIT_W-1:0]            cur_digit;
    logic                          cur_dp;
    logic                          lz_blank;
    logic [6:0]                    dec_seg;

    bcd_to_seg7 u_dec (
        .bcd   (cur_digit),
        .blank (lz_blank),
        .seg   (dec_seg)
    );

    // Outputs are computed from next-state values so they move on the same
    // edge as pre/idx and the freshly captured snapshot.
    always_comb begin
        pre_n      = pre + 1'b1;
        idx_n      = idx;
        snap_bcd_n = snap_bcd;
        snap_dp_n  = snap_dp;
        snap_lz_n  = snap_lz;
        tick_n     = 1'b0;
        if (pre == PRE_LAST) begin
            pre_n = '0;
            if (idx == IDX_LAST) begin
                idx_n      = '0;
                snap_bcd_n = BCD_IN;
                snap_dp_n  = DP_IN;
                snap_lz_n  = BLANK_LZ;
                tick_n     = 1'b1;
            end else begin
                idx_n = idx + 1'b1;
            end
        end

        phase_n = (pre_n < PRE_GAP) ? PH_BLANK : PH_SHOW;

        cur_digit = '0;
        cur_dp    = 1'b0;
        lz_blank  = snap_lz_n && (idx_n != '0);
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            if (IDX_W'(j) == idx_n) begin
                cur_digit = snap_bcd_n[j*DIGIT_W +: DIGIT_W];
                cur_dp    = snap_dp_n[j];
            end
            if ((32'(idx_n) <= j) && (snap_bcd_n[j*DIGIT_W +: DIGIT_W] != '0)) begin
                lz_blank = 1'b0;
            end
        end

        seg_n = SEG_IDLE;
        dp_n  = SEG_ACTIVE_LOW;
        dig_n = DIG_IDLE;
        if (phase_n == PH_SHOW) begin
            seg_n        = seg_pol(dec_seg, SEG_ACTIVE_LOW);
            dp_n         = cur_dp ^ SEG_ACTIVE_LOW;
            dig_n[idx_n] = ~DIG_IDLE[0];
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            pre      <= PRE_LAST;
            idx      <= IDX_LAST;
            snap_bcd <= '0;
            snap_dp  <= '0;
            snap_lz  <= 1'b0;
            seg_q    <= SEG_IDLE;
            dp_q     <= SEG_ACTIVE_LOW;
            dig_q    <= DIG_IDLE;
            tick_q   <= 1'b0;
        end else begin
            pre      <= pre_n;
            idx      <= idx_n;
            snap_bcd <= snap_bcd_n;
            snap_dp  <= snap_dp_n;
            snap_lz  <= snap_lz_n;
            seg_q    <= seg_n;
            dp_q     <= dp_n;
            dig_q    <= dig_n;
            tick_q   <= tick_n;
        end
    end

    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign DIG        = dig_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: 4 digits, 8-cycle slots, 2-cycle gap,
// active-low segments and digits. Edge 0 is the first edge after reset release.
module tb_bcd_display_scanner;

    logic        CLK_IN = 1'b0;
    logic        RST    = 1'b0;
    logic [15:0] BCD_IN;
    logic [3:0]  DP_IN;
    logic        BLANK_LZ;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  DIG;
    logic        FRAME_TICK;

    int cyc    = -1;
    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] tbl_seg [4];

    bcd_display_scanner #(
        .N_DIGITS       (4),
        .PRESCALE       (8),
        .GAP            (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK_IN     (CLK_IN),
        .RST        (RST),
        .BCD_IN     (BCD_IN),
        .DP_IN      (DP_IN),
        .BLANK_LZ   (BLANK_LZ),
        .SEG        (SEG),
        .DP         (DP),
        .DIG        (DIG),
        .FRAME_TICK (FRAME_TICK)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_IN);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk_show(input string tag, input logic [3:0] dig, input logic [6:0] seg);
        chk({tag, "_dig"}, 32'(DIG), 32'(dig));
        chk({tag, "_seg"}, 32'(SEG), 32'(seg));
    endtask

    initial begin
        BCD_IN   = 16'h1234;
        DP_IN    = 4'b0000;
        BLANK_LZ = 1'b0;

        #1 RST = 1'b1;
        #1;
        chk("rst_dig",  32'(DIG), 32'h0F);
        chk("rst_seg",  32'(SEG), 32'h7F);
        chk("rst_dp",   32'(DP), 32'h1);
        chk("rst_tick", 32'(FRAME_TICK), 32'h0);

        @(negedge CLK_IN);
        @(negedge CLK_IN);
        RST = 1'b0;

        // Full first frame, edge by edge: digits 4,3,2,1 from right to left.
        tbl_seg[0] = 7'h19;
        tbl_seg[1] = 7'h30;
        tbl_seg[2] = 7'h24;
        tbl_seg[3] = 7'h79;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("f0_tick", 32'(FRAME_TICK), (k == 0) ? 32'h1 : 32'h0);
            if ((k % 8) < 2) begin
                chk_show("f0_gap", 4'hF, 7'h7F);
            end else begin
                chk_show("f0_show", ~(4'b0001 << (k / 8)), tbl_seg[k / 8]);
            end
        end
        step_to(32);
        chk("f1_tick", 32'(FRAME_TICK), 32'h1);

        // Mid-frame input change is held off until the next snapshot.
        step_to(41);
        BCD_IN = 16'h5678;
        step_to(42);  chk_show("hold_d1", 4'b1101, 7'h30);
        step_to(50);  chk_show("hold_d2", 4'b1011, 7'h24);
        step_to(58);  chk_show("hold_d3", 4'b0111, 7'h79);
        step_to(63);  chk("hold_notick", 32'(FRAME_TICK), 32'h0);
        step_to(64);  chk("f2_tick", 32'(FRAME_TICK), 32'h1);
        step_to(66);  chk_show("new_d0", 4'b1110, 7'h00);
        step_to(74);  chk_show("new_d1", 4'b1101, 7'h78);
        step_to(82);  chk_show("new_d2", 4'b1011, 7'h02);
        step_to(90);  chk_show("new_d3", 4'b0111, 7'h12);

        // Leading-zero blanking with DIG still asserted.
        BCD_IN   = 16'h0005;
        BLANK_LZ = 1'b1;
        step_to(96);  chk("f3_tick", 32'(FRAME_TICK), 32'h1);
        step_to(98);  chk_show("lz_d0", 4'b1110, 7'h12);
        step_to(106); chk_show("lz_d1", 4'b1101, 7'h7F);
        step_to(114); chk_show("lz_d2", 4'b1011, 7'h7F);
        step_to(122); chk_show("lz_d3", 4'b0111, 7'h7F);

        BCD_IN = 16'h0000;
        step_to(130); chk_show("lz0_d0", 4'b1110, 7'h40);
        step_to(138); chk_show("lz0_d1", 4'b1101, 7'h7F);

        // Non-decimal code shows a dash; DP only during its own SHOW phase.
        BCD_IN   = 16'h00B0;
        DP_IN    = 4'b0010;
        BLANK_LZ = 1'b0;
        step_to(162); chk_show("dp_d0", 4'b1110, 7'h40);
        chk("dp_d0_dp", 32'(DP), 32'h1);
        step_to(168); chk("dp_gap_dp", 32'(DP), 32'h1);
        step_to(170); chk_show("dash_d1", 4'b1101, 7'h3F);
        chk("dp_d1_dp", 32'(DP), 32'h0);
        step_to(178); chk_show("dp_d2", 4'b1011, 7'h40);
        chk("dp_d2_dp", 32'(DP), 32'h1);

        // Interior zero is kept once a higher digit is non-zero.
        BCD_IN   = 16'h0305;
        DP_IN    = 4'b0000;
        BLANK_LZ = 1'b1;
        step_to(194); chk_show("mz_d0", 4'b1110, 7'h12);
        step_to(202); chk_show("mz_d1", 4'b1101, 7'h40);
        step_to(210); chk_show("mz_d2", 4'b1011, 7'h30);
        step_to(218); chk_show("mz_d3", 4'b0111, 7'h7F);

        // Asynchronous reset in the middle of a SHOW phase.
        #2 RST = 1'b1;
        #1;
        chk("arst_dig",  32'(DIG), 32'h0F);
        chk("arst_seg",  32'(SEG), 32'h7F);
        chk("arst_dp",   32'(DP), 32'h1);
        chk("arst_tick", 32'(FRAME_TICK), 32'h0);
        @(negedge CLK_IN);
        RST = 1'b0;
        cyc = -1;
        step();
        chk("rel_tick", 32'(FRAME_TICK), 32'h1);
        chk_show("rel_gap", 4'hF, 7'h7F);
        step_to(2);
        chk("rel_notick", 32'(FRAME_TICK), 32'h0);
        chk_show("rel_d0", 4'b1110, 7'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
